// File: rtl/pi_pwm_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : pi_pwm_driver_if
//  Purpose  : Bundles the controller-side sample input, the run enable and
//             the PWM-side outputs of pi_pwm_driver.
//  Revision : 1.0 - initial release
// ============================================================================
interface pi_pwm_driver_if #(
   parameter int IN_W  = 32,
   parameter int CNT_W = 16
);
   logic [IN_W-1:0]  u_in;
   logic             u_valid;
   logic             enable;
   logic             pwm_hi;
   logic             pwm_lo;
   logic             period_start;
   logic [CNT_W-1:0] duty_cur;
   logic             sat_flag;

   // Upstream controller / system side
   modport master (
      output u_in, u_valid, enable,
      input  pwm_hi, pwm_lo, period_start, duty_cur, sat_flag
   );

   // PWM driver side
   modport slave (
      input  u_in, u_valid, enable,
      output pwm_hi, pwm_lo, period_start, duty_cur, sat_flag
   );
endinterface
`default_nettype wire

// File: rtl/pi_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : pi_pwm_driver
//  Purpose  : Saturates/scales the PI controller output to a duty count,
//             double-buffers it per PWM period and drives a complementary
//             gate pair with dead time, plus a once-per-period strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module pi_pwm_driver #(
   parameter int IN_W     = 32,
   parameter int CNT_W    = 16,
   parameter int PERIOD   = 1000,
   parameter int SHIFT    = 0,
   parameter int DEADTIME = 4
) (
   input  wire                 clk,
   input  wire                 rst,
   pi_pwm_driver_if.slave      bus
);

   // Timer holds DEADTIME-1 down to 0, so a dead state spans DEADTIME cycles
   localparam int TMR_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
   localparam logic [TMR_W-1:0]       C_DT_RELOAD = TMR_W'(DEADTIME - 1);
   localparam logic [CNT_W-1:0]       C_CNT_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0]       C_DUTY_MAX  = CNT_W'(PERIOD);
   localparam logic signed [IN_W-1:0] C_PERIOD_S  = IN_W'(PERIOD);

   // Reject configurations the dead-time and period logic cannot honour
   if (DEADTIME < 1) begin : g_bad_deadtime
      $error("pi_pwm_driver: DEADTIME must be at least 1");
   end
   if (PERIOD < 2) begin : g_bad_period
      $error("pi_pwm_driver: PERIOD must be at least 2");
   end

   typedef enum logic [2:0] {
      ST_OFF        = 3'd0,
      ST_DEAD_TO_LO = 3'd1,
      ST_LO_ON      = 3'd2,
      ST_DEAD_TO_HI = 3'd3,
      ST_HI_ON      = 3'd4
   } state_t;

   logic signed [IN_W-1:0] shifted_w;
   logic [CNT_W-1:0]       clamped_w;
   logic                   clamp_hit_w;
   logic                   wrap_w;
   logic                   raw_w;

   logic [CNT_W-1:0]       cnt_q,          cnt_d;
   logic [CNT_W-1:0]       duty_pending_q;
   logic [CNT_W-1:0]       duty_active_q,  duty_active_d;
   logic                   sat_q;
   logic                   period_start_q;
   state_t                 state_q,        state_d;
   logic [TMR_W-1:0]       timer_q,        timer_d;
   logic                   from_hi_q,      from_hi_d;
   logic                   hi_q,           hi_d;
   logic                   lo_q,           lo_d;

   // Scale and clamp the incoming sample into the 0..PERIOD duty range
   always_comb begin
      shifted_w   = $signed(bus.u_in) >>> SHIFT;
      clamped_w   = shifted_w[CNT_W-1:0];
      clamp_hit_w = 1'b0;
      if (shifted_w < 0) begin
         clamped_w   = '0;
         clamp_hit_w = 1'b1;
      end else if (shifted_w > C_PERIOD_S) begin
         clamped_w   = C_DUTY_MAX;
         clamp_hit_w = 1'b1;
      end
   end

   // Capture accepted samples into the pending duty and saturation flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_pending_q <= '0;
         sat_q          <= 1'b0;
      end else if (bus.u_valid) begin
         duty_pending_q <= clamped_w;
         sat_q          <= clamp_hit_w;
      end
   end

   // Period counter; held at zero while disabled so a restart begins a fresh period
   always_comb begin
      wrap_w = bus.enable && (cnt_q == C_CNT_LAST);
      cnt_d  = '0;
      if (bus.enable && !wrap_w) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Shadow duty: reload only at the period boundary; a sample arriving on the
   // boundary cycle bypasses the pending register so it is not lost a period
   always_comb begin
      duty_active_d = duty_active_q;
      if (!bus.enable) begin
         duty_active_d = duty_pending_q;
      end else if (wrap_w) begin
         duty_active_d = bus.u_valid ? clamped_w : duty_pending_q;
      end
   end

   // Counter, active duty and period strobe registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q          <= '0;
         duty_active_q  <= '0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         duty_active_q  <= duty_active_d;
         period_start_q <= wrap_w;
      end
   end

   assign raw_w = (cnt_q < duty_active_q);

   // Dead-time FSM next state; gate outputs are decoded from the next state
   // so that they come straight out of flops
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      from_hi_d = from_hi_q;
      if (!bus.enable) begin
         state_d   = ST_OFF;
         timer_d   = '0;
         from_hi_d = 1'b0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d   = ST_DEAD_TO_LO;
               timer_d   = C_DT_RELOAD;
               from_hi_d = 1'b0;
            end
            ST_DEAD_TO_LO: begin
               if (from_hi_q && raw_w) begin
                  // Low side never turned on, high side may resume at once
                  state_d = ST_HI_ON;
               end else if (timer_q == '0) begin
                  if (raw_w) begin
                     state_d = ST_DEAD_TO_HI;
                     timer_d = C_DT_RELOAD;
                  end else begin
                     state_d = ST_LO_ON;
                  end
               end else begin
                  timer_d = timer_q - TMR_W'(1);
               end
            end
            ST_LO_ON: begin
               if (raw_w) begin
                  state_d = ST_DEAD_TO_HI;
                  timer_d = C_DT_RELOAD;
               end
            end
            ST_DEAD_TO_HI: begin
               if (!raw_w) begin
                  // Pulse shorter than the dead time is suppressed
                  state_d = ST_LO_ON;
               end else if (timer_q == '0) begin
                  state_d = ST_HI_ON;
               end else begin
                  timer_d = timer_q - TMR_W'(1);
               end
            end
            ST_HI_ON: begin
               if (!raw_w) begin
                  state_d   = ST_DEAD_TO_LO;
                  timer_d   = C_DT_RELOAD;
                  from_hi_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_OFF;
               timer_d = '0;
            end
         endcase
      end
      hi_d = (state_d == ST_HI_ON);
      lo_d = (state_d == ST_LO_ON);
   end

   // Dead-time FSM state, timer and registered gate drives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_OFF;
         timer_q   <= '0;
         from_hi_q <= 1'b0;
         hi_q      <= 1'b0;
         lo_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         from_hi_q <= from_hi_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.pwm_hi       = hi_q;
   assign bus.pwm_lo       = lo_q;
   assign bus.period_start = period_start_q;
   assign bus.duty_cur     = duty_active_q;
   assign bus.sat_flag     = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_pi_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pi_pwm_driver
//  Purpose  : Directed self-checking bench for pi_pwm_driver (PERIOD=1000,
//             DEADTIME=4; a second instance uses SHIFT=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pi_pwm_driver;

   logic clk = 1'b0;
   logic rst;
   int   n_err = 0;
   int   n_chk = 0;

   always #5 clk = ~clk;

   pi_pwm_driver_if #(.IN_W(32), .CNT_W(16)) if0 ();
   pi_pwm_driver_if #(.IN_W(32), .CNT_W(16)) if1 ();

   pi_pwm_driver #(.IN_W(32), .CNT_W(16), .PERIOD(1000), .SHIFT(0), .DEADTIME(4)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   pi_pwm_driver #(.IN_W(32), .CNT_W(16), .PERIOD(1000), .SHIFT(2), .DEADTIME(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n clocks; outputs are sampled 1 time unit after each rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance until period_start is seen (bounded); n returns ticks taken
   task automatic wait_ps(input string tag, output int n);
      n = 0;
      while (if0.period_start !== 1'b1 && n < 2000) begin
         tick(1);
         n++;
      end
      chk(tag, {31'd0, if0.period_start}, 32'd1);
   endtask

   // Observe one full period starting at the current (cnt=0) sample
   task automatic measure(output int hi_c, output int lo_c, output int ov_c,
                          output int ps_c, output int first_hi);
      hi_c = 0; lo_c = 0; ov_c = 0; ps_c = 0; first_hi = -1;
      for (int i = 0; i < 1000; i++) begin
         if (if0.pwm_hi === 1'b1) begin
            hi_c++;
            if (first_hi < 0) first_hi = i;
         end
         if (if0.pwm_lo === 1'b1) lo_c++;
         if (if0.pwm_hi === 1'b1 && if0.pwm_lo === 1'b1) ov_c++;
         if (if0.period_start === 1'b1) ps_c++;
         tick(1);
      end
   endtask

   // One-cycle sample into dut0
   task automatic push0(input int val);
      if0.u_in    = 32'(val);
      if0.u_valid = 1'b1;
      tick(1);
      if0.u_valid = 1'b0;
   endtask

   // Sample into the disabled SHIFT=2 instance and check the tracked duty
   task automatic push1(input string tag, input int val, input int exp_duty, input logic exp_sat);
      if1.u_in    = 32'(val);
      if1.u_valid = 1'b1;
      tick(1);
      if1.u_valid = 1'b0;
      tick(1);
      chk({tag, "_duty"}, {16'd0, if1.duty_cur}, 32'(exp_duty));
      chk({tag, "_sat"},  {31'd0, if1.sat_flag}, {31'd0, exp_sat});
   endtask

   initial begin
      int hi_c, lo_c, ov_c, ps_c, first_hi, n, act;

      rst = 1'b1;
      if0.u_in = '0; if0.u_valid = 1'b0; if0.enable = 1'b0;
      if1.u_in = '0; if1.u_valid = 1'b0; if1.enable = 1'b0;
      tick(3);

      // Reset state
      chk("rst_outs", {28'd0, if0.pwm_hi, if0.pwm_lo, if0.period_start, if0.sat_flag}, 32'd0);
      chk("rst_duty", {16'd0, if0.duty_cur}, 32'd0);

      // Idle after reset: nothing toggles
      rst = 1'b0;
      act = 0;
      for (int i = 0; i < 20; i++) begin
         if (if0.pwm_hi !== 1'b0 || if0.pwm_lo !== 1'b0 || if0.period_start !== 1'b0) act++;
         tick(1);
      end
      chk("idle_activity", 32'(act), 32'd0);

      // Duty 250, disabled: active duty tracks pending
      push0(250);
      tick(1);
      chk("t2_duty_cur", {16'd0, if0.duty_cur}, 32'd250);
      chk("t2_sat", {31'd0, if0.sat_flag}, 32'd0);
      if0.enable = 1'b1;
      wait_ps("t2_first_ps", n);
      chk("t2_first_ps_delay", 32'(n), 32'd1000);
      measure(hi_c, lo_c, ov_c, ps_c, first_hi);
      chk("t2_hi_cycles", 32'(hi_c), 32'd246);
      chk("t2_lo_cycles", 32'(lo_c), 32'd746);
      chk("t2_overlap", 32'(ov_c), 32'd0);
      chk("t2_ps_count", 32'(ps_c), 32'd1);
      chk("t2_first_hi", 32'(first_hi), 32'd5);
      chk("t2_ps_next", {31'd0, if0.period_start}, 32'd1);

      // Negative sample: clamp to 0, applies next period only
      push0(-5);
      chk("t3n_sat", {31'd0, if0.sat_flag}, 32'd1);
      chk("t3n_mid_duty", {16'd0, if0.duty_cur}, 32'd250);
      wait_ps("t3n_ps", n);
      chk("t3n_duty_cur", {16'd0, if0.duty_cur}, 32'd0);
      measure(hi_c, lo_c, ov_c, ps_c, first_hi);
      chk("t3n_hi_cycles", 32'(hi_c), 32'd0);
      chk("t3n_lo_cycles", 32'(lo_c), 32'd1000);

      // Over-range sample: clamp to PERIOD
      push0(5000);
      chk("t3p_sat", {31'd0, if0.sat_flag}, 32'd1);
      wait_ps("t3p_ps", n);
      chk("t3p_duty_cur", {16'd0, if0.duty_cur}, 32'd1000);
      measure(hi_c, lo_c, ov_c, ps_c, first_hi);
      chk("t3p_hi_entry", 32'(hi_c), 32'd995);
      chk("t3p_lo_entry", 32'(lo_c), 32'd1);
      measure(hi_c, lo_c, ov_c, ps_c, first_hi);
      chk("t3p_hi_full", 32'(hi_c), 32'd1000);
      chk("t3p_lo_full", 32'(lo_c), 32'd0);

      // Exactly PERIOD is in range, not a clamp
      push0(1000);
      chk("t3e_sat", {31'd0, if0.sat_flag}, 32'd0);
      chk("t3e_duty", {16'd0, if0.duty_cur}, 32'd1000);

      // Shadow: mid-period sample does not touch the running period
      push0(250);
      wait_ps("t4_ps_a", n);
      chk("t4_duty_a", {16'd0, if0.duty_cur}, 32'd250);
      tick(500);
      push0(600);
      chk("t4_mid_duty", {16'd0, if0.duty_cur}, 32'd250);
      wait_ps("t4_ps_b", n);
      chk("t4_wait_b", 32'(n), 32'd499);
      chk("t4_duty_b", {16'd0, if0.duty_cur}, 32'd600);
      measure(hi_c, lo_c, ov_c, ps_c, first_hi);
      chk("t4_hi_600", 32'(hi_c), 32'd596);
      chk("t4_lo_600", 32'(lo_c), 32'd396);
      chk("t4_ov_600", 32'(ov_c), 32'd0);

      // Bypass: sample on the last cycle of the period
      tick(999);
      push0(100);
      chk("t4_byp_ps", {31'd0, if0.period_start}, 32'd1);
      chk("t4_byp_duty", {16'd0, if0.duty_cur}, 32'd100);

      // Duty shorter than dead time: high side suppressed
      push0(3);
      wait_ps("t5_ps", n);
      chk("t5_duty", {16'd0, if0.duty_cur}, 32'd3);
      measure(hi_c, lo_c, ov_c, ps_c, first_hi);
      chk("t5_hi_cycles", 32'(hi_c), 32'd0);
      chk("t5_lo_cycles", 32'(lo_c), 32'd997);

      // Disable while high side is on, then restart
      push0(250);
      wait_ps("t6_ps", n);
      tick(100);
      chk("t6_hi_before", {31'd0, if0.pwm_hi}, 32'd1);
      if0.enable = 1'b0;
      tick(1);
      chk("t6_off_outs", {30'd0, if0.pwm_hi, if0.pwm_lo}, 32'd0);
      tick(5);
      chk("t6_off_hold", {29'd0, if0.pwm_hi, if0.pwm_lo, if0.period_start}, 32'd0);
      if0.enable = 1'b1;
      act = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (if0.pwm_hi !== 1'b0 || if0.pwm_lo !== 1'b0 || if0.period_start !== 1'b0) act++;
      end
      chk("t6_restart_dead", 32'(act), 32'd0);
      tick(1);
      chk("t6_restart_hi", {31'd0, if0.pwm_hi}, 32'd1);
      wait_ps("t6_restart_ps", n);
      chk("t6_restart_ps_delay", 32'(n), 32'd991);

      // Asynchronous reset mid-operation
      tick(50);
      chk("t7_hi_running", {31'd0, if0.pwm_hi}, 32'd1);
      #2;
      rst = 1'b1;
      if0.enable = 1'b0;
      #1;
      chk("t7_async_outs", {28'd0, if0.pwm_hi, if0.pwm_lo, if0.period_start, if0.sat_flag}, 32'd0);
      chk("t7_async_duty", {16'd0, if0.duty_cur}, 32'd0);
      tick(2);
      rst = 1'b0;
      tick(3);
      chk("t7_after_rst", {29'd0, if0.pwm_hi, if0.pwm_lo, if0.period_start}, 32'd0);

      // SHIFT=2 scaling and its clamp boundaries
      push1("s2_1000", 1000, 250, 1'b0);
      push1("s2_4003", 4003, 1000, 1'b0);
      push1("s2_4004", 4004, 1000, 1'b1);
      push1("s2_neg1", -1, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
